// File: rtl/sky_xu_wb_arbiter.sv
// Writeback arbiter and register scoreboard for one skylark XU.
// Round-robin shares the register-file write port; a busy mask tracks pending destinations.
module sky_xu_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic                    rf_write_enable,
  output logic [3:0]              rf_write_addr,
  output logic [31:0]             rf_write_data,
  input  logic                    claim_valid,
  input  logic [3:0]              claim_addr,
  output logic                    claim_ok,
  output logic [15:0]             busy_mask
);

  localparam int unsigned PTR_W  = $clog2(NUM_REQ);
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;
  logic [NREG-1:0]   busy_next;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    int unsigned pos;
    grant_any = 1'b0;
    grant_idx = '0;
    pos       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!grant_any && req_valid[PTR_W'(pos)]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(pos);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // Payload of the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        sel_addr = req_addr[k*ADDR_W +: ADDR_W];
        sel_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr_next = '0;
      else                                  ptr_next = grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= '0;
    else          ptr <= ptr_next;
  end

  // Registered write port; address 0 consumes its grant without writing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else if (grant_any) begin
      rf_write_enable <= (sel_addr != '0);
      rf_write_addr   <= sel_addr;
      rf_write_data   <= sel_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  // Scoreboard: a claim is refused while the bit is set, so a same-register
  // claim and clear resolves to the clear.
  always_comb begin
    claim_ok  = (claim_addr == '0) | ~busy_mask[claim_addr];
    set_mask  = '0;
    clr_mask  = '0;
    if (claim_valid && claim_ok && (claim_addr != '0))
      set_mask = NREG'(1) << claim_addr;
    if (rf_write_enable)
      clr_mask = NREG'(1) << rf_write_addr;
    busy_next    = (busy_mask & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_mask <= '0;
    else          busy_mask <= busy_next;
  end

endmodule

// File: doc/sky_xu_wb_arbiter.md
# sky_xu_wb_arbiter

Writeback arbiter and register scoreboard for one skylark XU. It shares the single write port of the XU's 16×32 register file (register 0 hardwired to zero) between NUM_REQ writeback sources (ALU, load unit, etc.) using round-robin arbitration. It also keeps a per-register busy mask so that issue logic can stall on pending destinations. It sits between the execute/memory stages and the register file write port.

## Interface
- NUM_REQ, default 3: number of writeback requesters, 2..8.
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester writeback request.
- req_ready  out  NUM_REQ  per-requester grant; handshake = valid & ready.
- req_addr  in  4*NUM_REQ  destination register; requester i at [4i+3:4i].
- req_data  in  32*NUM_REQ  writeback data; requester i at [32i+31:32i].
- rf_write_enable  out  1  register file write enable.
- rf_write_addr  out  4  register file write address.
- rf_write_data  out  32  register file write data.
- claim_valid  in  1  issue stage reserves a destination register.
- claim_addr  in  4  register being reserved.
- claim_ok  out  1  combinational: claim can be accepted this cycle.
- busy_mask  out  16  bit r = register r has a pending write; bit 0 always 0.

## Operation
- Arbitration state: pointer ptr, range 0..NUM_REQ-1. Scan starts at ptr, ascending, modulo NUM_REQ. The first requester found with req_valid=1 is granted.
- req_ready is combinational and one-hot or zero. It goes to the granted requester only. It does not depend on that requester's own ready history.
- On a handshake with requester g: ptr <= (g+1) mod NUM_REQ. With no valid request, ptr holds.
- Requesters hold valid, addr and data stable until the handshake. The arbiter never drops an accepted request.
- Output stage, registered: on a handshake, the next cycle drives rf_write_enable=(addr!=0), rf_write_addr=addr, rf_write_data=data. With no handshake, rf_write_enable=0 and addr/data hold their last value.
- A request to address 0 is accepted, consumes its grant, and produces no write.
- Scoreboard, claims: claim_ok = (claim_addr==0) | ~busy_mask[claim_addr]. A claim with claim_valid & claim_ok & claim_addr!=0 sets busy bit at the edge. A claim with claim_ok=0 is ignored; the issue stage must stall.
- Scoreboard, clears: a busy bit clears on the edge where rf_write_enable=1 and rf_write_addr matches. This is the same edge on which the register file captures the data, so a read issued after the bit clears sees new data.
- Simultaneous claim and clear of the same register: claim_ok is 0 because the bit is still set. The clear takes effect and the claim is ignored.
- Claim and clear of different registers in the same cycle: both take effect.
- A writeback to a non-busy register is legal. The write occurs and busy_mask is unchanged.

## Timing
- Reset (reset_n=0, asynchronous): ptr=0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0, busy_mask=0. req_ready follows combinationally from req_valid with ptr=0.
- Reset mid-operation: any registered in-flight write is discarded and all busy bits clear.
- Latency: handshake in cycle t gives rf_write_enable high during cycle t+1. The register file is written and the busy bit cleared at the end of cycle t+1.
- Throughput: one writeback per cycle sustained. With k continuously-valid requesters, each is granted once every k cycles.
- claim_ok and req_ready have no registered delay. busy_mask is a direct register output.

## Test plan
- Reset and single write: after reset, requester 1 sends valid with addr=5, data=0xDEADBEEF. Required: ready[1]=1 in the same cycle, rf_write_enable=1 / addr=5 / data=0xDEADBEEF in the next cycle, then idle with rf_write_enable=0.
- Round-robin fairness: NUM_REQ=3, all valid continuously. Required grant order 0,1,2,0,1,2, one grant per cycle, req_ready always one-hot.
- Scoreboard: claim r7 → busy_mask=0x0080, and a second claim of r7 gives claim_ok=0. Writeback to r7 → bit 7 clears on the edge where rf_write_enable is high. Claim r7 in that same cycle → ignored, busy_mask=0 afterwards.
- Address 0: claim r0 gives claim_ok=1 and busy_mask stays 0. Writeback to r0 gets a handshake but rf_write_enable stays 0.
- Async reset mid-flight: assert reset_n=0 between a handshake and the write cycle, with busy_mask=0x00F0. Required: rf_write_enable=0 and busy_mask=0 immediately, ptr=0 after release.
- Hold under contention: requester 2 holds valid for 3 cycles while requesters 0 and 1 are also valid with ptr=0. Required: grants go 0, 1, 2, and requester 2's addr/data are written exactly once.
